// File: rtl/sram_log_pkg.sv
// ============================================================================
// Module   : sram_log_pkg
// Brief    : Shared constants, write-side FSM encoding and byte-lane helper
//            for the sample RAM log writer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_log_pkg;

  localparam int c_default_lanes = 4;

  typedef enum logic [0:0] {
    W_IDLE  = 1'b0,
    W_WRITE = 1'b1
  } wr_state_t;

  // True when byte b of the RAM word belongs to sample lane `lane`.
  function automatic logic lane_byte_en(input int b, input int lane, input int bytes_per_lane);
    return (b >= lane * bytes_per_lane) && (b < (lane + 1) * bytes_per_lane);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_log_packer.sv
// ============================================================================
// Module   : sram_log_packer
// Brief    : Packs stream samples into RAM-word lanes and hands full or
//            flushed partial words to the holding stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_log_packer
  import sram_log_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int SAMPLE_W = 32
) (
  input  logic                  clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [SAMPLE_W-1:0]   i_snk_data,
  input  logic                  i_snk_valid,
  output logic                  o_snk_ready,
  input  logic                  i_flush,
  input  logic                  i_hold_busy,
  input  logic                  i_hold_free,
  output logic                  o_load,
  output logic [DATA_W-1:0]     o_load_data,
  output logic [DATA_W/8-1:0]   o_load_be
);

  localparam int c_lanes = DATA_W / SAMPLE_W;
  localparam int c_bpl   = SAMPLE_W / 8;
  localparam int c_be_w  = DATA_W / 8;
  localparam int c_cnt_w = $clog2(c_lanes + 1);

  logic [DATA_W-1:0]  r_pack;
  logic [c_be_w-1:0]  r_pack_be;
  logic [c_cnt_w-1:0] r_lane_cnt;
  logic               r_flush_pend;

  logic [DATA_W-1:0]  w_pack_data;
  logic [c_be_w-1:0]  w_pack_be;
  logic [c_cnt_w-1:0] w_lanes_after;
  logic               w_lane_last;
  logic               w_accept;
  logic               w_full;
  logic               w_flush_req;
  logic               w_flush_load;

  // The last lane may only be taken when holding is idle, so a full word
  // always has somewhere to go; waitrequest never reaches this path.
  assign w_lane_last = (r_lane_cnt == c_cnt_w'(c_lanes - 1));
  assign o_snk_ready = i_enable & ~i_reset & ~(w_lane_last & i_hold_busy) & ~r_flush_pend;
  assign w_accept    = i_snk_valid & o_snk_ready;

  always_comb begin
    w_pack_data = r_pack;
    w_pack_be   = r_pack_be;
    for (int l = 0; l < c_lanes; l++) begin
      if (w_accept && (r_lane_cnt == c_cnt_w'(l))) begin
        w_pack_data[l*SAMPLE_W +: SAMPLE_W] = i_snk_data;
        for (int b = 0; b < c_be_w; b++) begin
          if (lane_byte_en(b, l, c_bpl)) begin
            w_pack_be[b] = 1'b1;
          end
        end
      end
    end
  end

  assign w_lanes_after = w_accept ? (r_lane_cnt + c_cnt_w'(1)) : r_lane_cnt;
  assign w_full        = w_accept & w_lane_last;
  assign w_flush_req   = i_flush | r_flush_pend;
  // A flush coinciding with the last lane is absorbed by the full-word load.
  assign w_flush_load  = w_flush_req & (w_lanes_after != '0) & i_hold_free & ~w_full;

  assign o_load      = w_full | w_flush_load;
  assign o_load_data = w_pack_data;
  assign o_load_be   = w_pack_be;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_pack       <= '0;
      r_pack_be    <= '0;
      r_lane_cnt   <= '0;
      r_flush_pend <= 1'b0;
    end else if (o_load) begin
      r_pack       <= '0;
      r_pack_be    <= '0;
      r_lane_cnt   <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_pack       <= w_pack_data;
      r_pack_be    <= w_pack_be;
      r_lane_cnt   <= w_lanes_after;
      r_flush_pend <= w_flush_req & (w_lanes_after != '0);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_log_writer.sv
// ============================================================================
// Module   : sram_log_writer
// Brief    : Avalon-MM write master logging packed sensor samples into a
//            circular region of the sample RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_log_writer
  import sram_log_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int SAMPLE_W = 32,
  parameter int ADDR_W   = 13,
  parameter int DEPTH    = 8000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [SAMPLE_W-1:0]   snk_data,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  input  logic                  flush,
  output logic [ADDR_W-1:0]     m_address,
  output logic [DATA_W/8-1:0]   m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  input  logic                  m_waitrequest,
  output logic [ADDR_W-1:0]     wr_ptr,
  output logic [ADDR_W:0]       word_count,
  output logic                  wrapped
);

  localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   c_depth    = (ADDR_W + 1)'(DEPTH);

  generate
    if ((DATA_W % SAMPLE_W != 0) || (SAMPLE_W % 8 != 0) || (DEPTH > (1 << ADDR_W))) begin : g_bad_params
      $error("sram_log_writer: unsupported DATA_W/SAMPLE_W/DEPTH combination");
    end
  endgenerate

  wr_state_t             r_state;
  logic [ADDR_W-1:0]     r_m_address;
  logic [DATA_W/8-1:0]   r_m_byteenable;
  logic [DATA_W-1:0]     r_m_writedata;
  logic                  r_m_write;
  logic                  r_m_chipselect;
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W:0]       r_word_count;
  logic                  r_wrapped;

  logic                  w_hold_busy;
  logic                  w_hold_free;
  logic                  w_load;
  logic [DATA_W-1:0]     w_load_data;
  logic [DATA_W/8-1:0]   w_load_be;
  logic                  w_ptr_wrap;
  logic [ADDR_W-1:0]     w_ptr_next;

  assign w_hold_busy = (r_state == W_WRITE);
  assign w_hold_free = ~w_hold_busy | ~m_waitrequest;
  assign w_ptr_wrap  = (r_wr_ptr == c_last_ptr);
  assign w_ptr_next  = w_ptr_wrap ? '0 : (r_wr_ptr + ADDR_W'(1));

  sram_log_packer #(
    .DATA_W   (DATA_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_packer (
    .clk         (clk),
    .i_reset     (reset),
    .i_enable    (enable),
    .i_snk_data  (snk_data),
    .i_snk_valid (snk_valid),
    .o_snk_ready (snk_ready),
    .i_flush     (flush),
    .i_hold_busy (w_hold_busy),
    .i_hold_free (w_hold_free),
    .o_load      (w_load),
    .o_load_data (w_load_data),
    .o_load_be   (w_load_be)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= W_IDLE;
      r_m_address    <= '0;
      r_m_byteenable <= '0;
      r_m_writedata  <= '0;
      r_m_write      <= 1'b0;
      r_m_chipselect <= 1'b0;
      r_wr_ptr       <= '0;
      r_word_count   <= '0;
      r_wrapped      <= 1'b0;
    end else begin
      case (r_state)
        W_IDLE: begin
          if (w_load) begin
            r_m_address    <= r_wr_ptr;
            r_m_byteenable <= w_load_be;
            r_m_writedata  <= w_load_data;
            r_m_write      <= 1'b1;
            r_m_chipselect <= 1'b1;
            r_state        <= W_WRITE;
          end
        end
        W_WRITE: begin
          if (!m_waitrequest) begin
            r_wr_ptr <= w_ptr_next;
            if (w_ptr_wrap) begin
              r_wrapped <= 1'b1;
            end
            if (r_word_count != c_depth) begin
              r_word_count <= r_word_count + (ADDR_W + 1)'(1);
            end
            // Back-to-back: the next word targets the pointer just advanced.
            if (w_load) begin
              r_m_address    <= w_ptr_next;
              r_m_byteenable <= w_load_be;
              r_m_writedata  <= w_load_data;
            end else begin
              r_m_write      <= 1'b0;
              r_m_chipselect <= 1'b0;
              r_state        <= W_IDLE;
            end
          end
        end
        default: r_state <= W_IDLE;
      endcase
    end
  end

  assign m_address    = r_m_address;
  assign m_byteenable = r_m_byteenable;
  assign m_writedata  = r_m_writedata;
  assign m_write      = r_m_write;
  assign m_chipselect = r_m_chipselect;
  assign wr_ptr       = r_wr_ptr;
  assign word_count   = r_word_count;
  assign wrapped      = r_wrapped;

endmodule

`default_nettype wire

// File: tb/tb_sram_log_writer.sv
// ============================================================================
// Module   : tb_sram_log_writer
// Brief    : Scoreboard bench for sram_log_writer with a small log (DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_log_writer;

  localparam int TB_DEPTH = 8;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [31:0]  snk_data;
  logic         snk_valid;
  logic         snk_ready;
  logic         flush;
  logic [12:0]  m_address;
  logic [15:0]  m_byteenable;
  logic         m_chipselect;
  logic         m_write;
  logic [127:0] m_writedata;
  logic         m_waitrequest;
  logic [12:0]  wr_ptr;
  logic [13:0]  word_count;
  logic         wrapped;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [12:0]  addr;
    logic [15:0]  be;
    logic [127:0] data;
  } exp_t;

  exp_t         q[$];
  logic [127:0] cur_data;
  logic [15:0]  cur_be;
  int           cur_lane;
  int           n_words;

  sram_log_writer #(
    .DATA_W   (128),
    .SAMPLE_W (32),
    .ADDR_W   (13),
    .DEPTH    (TB_DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .snk_data      (snk_data),
    .snk_valid     (snk_valid),
    .snk_ready     (snk_ready),
    .flush         (flush),
    .m_address     (m_address),
    .m_byteenable  (m_byteenable),
    .m_chipselect  (m_chipselect),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .wr_ptr        (wr_ptr),
    .word_count    (word_count),
    .wrapped       (wrapped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word();
    exp_t e;
    e.addr = 13'(n_words % TB_DEPTH);
    e.be   = cur_be;
    e.data = cur_data;
    q.push_back(e);
    n_words++;
    cur_data = '0;
    cur_be   = '0;
    cur_lane = 0;
  endtask

  task automatic clear_model();
    q.delete();
    cur_data = '0;
    cur_be   = '0;
    cur_lane = 0;
    n_words  = 0;
  endtask

  // Offers one sample; f raises flush only in the cycle it is accepted.
  task automatic send(input logic [31:0] d, input logic f);
    logic acc;
    acc       = 1'b0;
    snk_data  = d;
    snk_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc   = snk_ready;
      flush = f & acc;
      @(posedge clk);
      #1;
      flush = 1'b0;
    end
    snk_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: sample 0x%h never accepted", d);
    end else begin
      cur_data[cur_lane*32 +: 32] = d;
      cur_be[cur_lane*4 +: 4]     = 4'hF;
      cur_lane++;
      if (cur_lane == 4 || f) push_word();
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (cur_lane != 0) push_word();
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int k = 0; k < 500 && !done; k++) begin
      @(posedge clk);
      #2;
      done = (q.size() == 0) && (m_write === 1'b0);
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d words still expected, m_write=%b", q.size(), m_write);
    end
  endtask

  task automatic chk_state(input string tag, input int ptr, input int cnt, input logic wr);
    chk({tag, "_wr_ptr"}, 64'(wr_ptr), 64'(ptr));
    chk({tag, "_word_count"}, 64'(word_count), 64'(cnt));
    chk({tag, "_wrapped"}, 64'(wrapped), 64'(wr));
  endtask

  // Every cycle a write is presented it must match the scoreboard head,
  // which also proves the bus holds steady across waitrequest stalls.
  always @(negedge clk) begin
    if (reset === 1'b0 && m_write === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: addr 0x%h be 0x%h data 0x%h", m_address, m_byteenable, m_writedata);
      end else begin
        if ({m_chipselect, m_address, m_byteenable, m_writedata} !== {1'b1, q[0].addr, q[0].be, q[0].data}) begin
          n_err++;
          $display("FAIL write_word: got cs %b addr 0x%h be 0x%h data 0x%h, expected addr 0x%h be 0x%h data 0x%h",
                   m_chipselect, m_address, m_byteenable, m_writedata, q[0].addr, q[0].be, q[0].data);
        end
        if (m_waitrequest === 1'b0) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic seen;
    reset         = 1'b1;
    enable        = 1'b1;
    snk_valid     = 1'b0;
    snk_data      = '0;
    flush         = 1'b0;
    m_waitrequest = 1'b0;
    clear_model();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_write", 64'(m_write), 0);
    chk("rst_m_chipselect", 64'(m_chipselect), 0);
    chk("rst_m_address", 64'(m_address), 0);
    chk("rst_ready_in_reset", 64'(snk_ready), 0);
    chk_state("rst", 0, 0, 1'b0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 64'(snk_ready), 1);

    // Full word.
    send(32'h11111111, 1'b0);
    send(32'h22222222, 1'b0);
    send(32'h33333333, 1'b0);
    send(32'h44444444, 1'b0);
    drain();
    chk_state("full_word", 1, 1, 1'b0);

    // Partial flush, then a full word proves the lane counter restarted.
    send(32'hAAAA0001, 1'b0);
    send(32'hBBBB0002, 1'b0);
    do_flush();
    drain();
    chk_state("partial", 2, 2, 1'b0);
    for (int i = 0; i < 4; i++) send(32'hC0DE0000 + 32'(i), 1'b0);
    drain();
    chk_state("after_partial", 3, 3, 1'b0);

    // Disabled stream keeps its partial word; flush still honoured.
    send(32'h5A5A5A5A, 1'b0);
    send(32'h6B6B6B6B, 1'b0);
    enable = 1'b0;
    #1;
    chk("ready_disabled", 64'(snk_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    do_flush();
    drain();
    enable = 1'b1;
    chk_state("disabled_flush", 4, 4, 1'b0);

    // Five stalled cycles with a continuous stream of 12 samples.
    m_waitrequest = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) send(32'h70000000 + 32'(i), 1'b0);
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
          @(posedge clk);
          #1;
          seen = m_write;
        end
        if (!seen) begin
          n_cmp++;
          n_err++;
          $display("FAIL stall_no_write: m_write never rose");
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("ready_blocked_in_stall", 64'(snk_ready), 0);
        @(posedge clk);
        #1;
        m_waitrequest = 1'b0;
      end
    join
    drain();
    chk_state("stall", 7, 7, 1'b0);

    // Flush together with the 4th sample: one full write, and the 8th wraps.
    send(32'h80000001, 1'b0);
    send(32'h80000002, 1'b0);
    send(32'h80000003, 1'b0);
    send(32'h80000004, 1'b1);
    drain();
    chk_state("flush_on_full", 0, 8, 1'b1);

    // Wrap from a clean reset: 36 samples, addresses 0..7 then 0.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 28; i++) send(32'h10000000 + 32'(i), 1'b0);
    drain();
    chk_state("wrap_7", 7, 7, 1'b0);
    for (int i = 28; i < 32; i++) send(32'h10000000 + 32'(i), 1'b0);
    drain();
    chk_state("wrap_8", 0, 8, 1'b1);
    for (int i = 32; i < 36; i++) send(32'h10000000 + 32'(i), 1'b0);
    drain();
    chk_state("wrap_9", 1, 8, 1'b1);

    // Reset while a write is stalled abandons it.
    m_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h90000000 + 32'(i), 1'b0);
    seen = m_write;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = m_write;
    end
    chk("stalled_write_present", 64'(seen), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_abandon_m_write", 64'(m_write), 0);
    chk_state("reset_abandon", 0, 0, 1'b0);
    reset         = 1'b0;
    m_waitrequest = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) send(32'hA0000000 + 32'(i), 1'b0);
    drain();
    chk_state("post_reset", 1, 1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
